// File: rtl/register_file_pkg.sv
// Shared types and widths for the register-file port scheduler.
// Consumers import register_file_pkg::*.
package register_file_pkg;

   localparam int XLEN = 64;
   localparam int AW   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD2  = 2'd1,
      RESP = 2'd2
   } rf_sched_state_t;

   typedef logic [AW-1:0] rf_idx_t;

endpackage

// File: rtl/register_file_port_scheduler.sv
// Shares one register-file port between operand fetch and writeback.
// Build option REGFILE_PORT_SCHED_FAST_READ_EN skips the rs2 cycle when it is redundant.
module register_file_port_scheduler
   import register_file_pkg::*;
#(
   parameter int XLEN = register_file_pkg::XLEN,
   parameter int AW   = register_file_pkg::AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AW-1:0]   req_rs1,
   input  logic [AW-1:0]   req_rs2,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rs1_data,
   output logic [XLEN-1:0] rsp_rs2_data,
   input  logic            wb_valid,
   output logic            wb_ready,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            rf_cs,
   output logic            rf_we,
   output logic [AW-1:0]   rf_addr,
   output logic [XLEN-1:0] rf_wr_data,
   input  logic [XLEN-1:0] rf_rd_data
);

   rf_sched_state_t r_state;
   logic            r_rd_prio;
   logic            r_rsp_valid;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [AW-1:0]   r_rs2_idx;

   logic w_idle;
   logic w_resp;
   logic w_wr_grant;
   logic w_rd_grant;
   logic w_fast;
   logic w_rs2_zero;

   assign w_idle = (r_state == IDLE);
   assign w_resp = (r_state == RESP);
   assign w_rs2_zero = (req_rs2 == '0);

   // In RESP no read can contend, so a waiting write always gets the port.
   assign w_wr_grant = wb_valid &&
      (w_resp || (w_idle && (!req_valid || !r_rd_prio)));
   assign w_rd_grant = w_idle && req_valid && !w_wr_grant;

`ifdef REGFILE_PORT_SCHED_FAST_READ_EN
   assign w_fast = (req_rs2 == req_rs1) || w_rs2_zero;
`else
   assign w_fast = 1'b0;
`endif

   assign req_ready    = w_rd_grant;
   assign wb_ready     = w_wr_grant;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rs1_data = r_rs1_data;
   assign rsp_rs2_data = r_rs2_data;
   assign rf_wr_data   = wb_data;

   always_comb begin
      rf_cs   = 1'b0;
      rf_we   = 1'b0;
      rf_addr = '0;
      unique case (1'b1)
         w_wr_grant: begin
            rf_cs   = 1'b1;
            rf_we   = 1'b1;
            rf_addr = wb_rd;
         end
         w_rd_grant: begin
            rf_cs   = 1'b1;
            rf_addr = req_rs1;
         end
         (r_state == RD2): begin
            rf_cs   = 1'b1;
            rf_addr = r_rs2_idx;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rd_prio   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_rs2_idx   <= '0;
      end else begin
         if (w_wr_grant) begin
            r_rd_prio <= req_valid;
         end
         unique case (r_state)
            IDLE: begin
               if (w_rd_grant) begin
                  r_rs1_data <= rf_rd_data;
                  r_rs2_idx  <= req_rs2;
                  r_rd_prio  <= 1'b0;
                  if (w_fast) begin
                     r_rs2_data  <= w_rs2_zero ? '0 : rf_rd_data;
                     r_rsp_valid <= 1'b1;
                     r_state     <= RESP;
                  end else begin
                     r_state <= RD2;
                  end
               end
            end
            RD2: begin
               r_rs2_data  <= rf_rd_data;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_register_file_port_scheduler.sv
// Scoreboard bench for register_file_port_scheduler with a register-file model.
// Honours REGFILE_PORT_SCHED_FAST_READ_EN for expected response latency.
module tb_register_file_port_scheduler;
   import register_file_pkg::*;

   localparam int XW = 64;
   localparam int AWW = 5;
`ifdef REGFILE_PORT_SCHED_FAST_READ_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0;
   logic req_ready;
   logic [AWW-1:0] req_rs1 = '0;
   logic [AWW-1:0] req_rs2 = '0;
   logic rsp_valid;
   logic rsp_ready = 1'b0;
   logic [XW-1:0] rsp_rs1_data;
   logic [XW-1:0] rsp_rs2_data;
   logic wb_valid = 1'b0;
   logic wb_ready;
   logic [AWW-1:0] wb_rd = '0;
   logic [XW-1:0] wb_data = '0;
   logic rf_cs;
   logic rf_we;
   logic [AWW-1:0] rf_addr;
   logic [XW-1:0] rf_wr_data;
   logic [XW-1:0] rf_rd_data;

   register_file_port_scheduler #(.XLEN(XW), .AW(AWW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_cs(rf_cs), .rf_we(rf_we), .rf_addr(rf_addr),
      .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data)
   );

   always #5 clk = ~clk;

   // Register file the scheduler drives: x0 hardwired, write on clock edge.
   logic [XW-1:0] rf_mem [32] = '{default: '0};
   assign rf_rd_data = (rf_addr == '0) ? '0 : rf_mem[rf_addr];
   always @(posedge clk) begin
      if (rf_cs && rf_we && rf_addr != '0) rf_mem[rf_addr] <= rf_wr_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference: architectural register values as seen by accepted writes.
   logic [XW-1:0] arch [32] = '{default: '0};

   typedef struct {
      logic [XW-1:0] d1;
      logic [XW-1:0] d2;
      int            acc;
      int            lat;
   } exp_t;
   exp_t sbq[$];
   bit head_seen = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         head_seen = 1'b0;
      end else begin
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               chk("spurious_rsp", 64'(rsp_valid), 0);
            end else begin
               if (!head_seen) begin
                  chk("rsp_latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                  head_seen = 1'b1;
               end
               chk("rs1_data", rsp_rs1_data, sbq[0].d1);
               chk("rs2_data", rsp_rs2_data, sbq[0].d2);
               if (rsp_ready) begin
                  void'(sbq.pop_front());
                  head_seen = 1'b0;
               end
            end
         end else if (sbq.size() > 0 && !head_seen &&
                      (cyc - sbq[0].acc) > sbq[0].lat) begin
            chk("rsp_latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
            head_seen = 1'b1;
         end
         if (wb_valid && wb_ready && wb_rd != '0) arch[wb_rd] = wb_data;
         if (req_valid && req_ready) begin
            exp_t e;
            e.d1  = arch[req_rs1];
            e.d2  = arch[req_rs2];
            e.acc = cyc;
            e.lat = (FAST && (req_rs2 == req_rs1 || req_rs2 == '0)) ? 1 : 2;
            sbq.push_back(e);
         end
      end
   end

   task automatic do_wb(input logic [4:0] rd, input logic [63:0] d);
      bit got = 1'b0;
      wb_valid = 1'b1; wb_rd = rd; wb_data = d;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk); got = wb_ready;
      end
      chk("wb_accept", 64'(got), 1);
      @(posedge clk); #1; wb_valid = 1'b0;
   endtask

   task automatic do_req(input logic [4:0] a, input logic [4:0] b);
      bit got = 1'b0;
      req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk); got = req_ready;
      end
      chk("req_accept", 64'(got), 1);
      @(posedge clk); #1; req_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk); done = (sbq.size() == 0) && !rsp_valid;
      end
      chk("sb_empty", 64'(sbq.size()), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      bit prev_acc;
      int gap;
      int n_acc;
      bit w;
      bit wbhs;
      bit rqhs;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rs1", rsp_rs1_data, 0);
      chk("rst_rs2", rsp_rs2_data, 0);
      chk("rst_rf_cs", 64'(rf_cs), 0);
      chk("rst_rf_addr", 64'(rf_addr), 0);
      chk("rst_req_ready", 64'(req_ready), 0);
      @(posedge clk); #1; rst = 1'b0;

      // Write then read x5 with x0 as rs2.
      rsp_ready = 1'b1;
      do_wb(5'd5, 64'hDEAD_BEEF);
      do_req(5'd5, 5'd0);
      drain();

      // Same-cycle write and read: write first.
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h1234;
      req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7;
      @(negedge clk);
      chk("tie_wb_first", 64'(wb_ready), 1);
      chk("tie_rd_wait", 64'(req_ready), 0);
      chk("tie_rf_we", 64'(rf_we), 1);
      @(posedge clk); #1; wb_valid = 1'b0;
      @(negedge clk);
      chk("tie_rd_next", 64'(req_ready), 1);
      chk("tie_rf_addr", 64'(rf_addr), 7);
      @(posedge clk); #1; req_valid = 1'b0;
      drain();

      // Continuous writeback alongside a pending read.
      wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 64'h10;
      req_valid = 1'b1; req_rs1 = 5'd10; req_rs2 = 5'd11;
      prev_acc = 1'b0; gap = 0; n_acc = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         gap++;
         if (req_ready) begin
            chk("rd_wait", 64'(gap <= 3), 1);
            chk("wb_ready_rdgrant", 64'(wb_ready), 0);
            gap = 0; n_acc++; prev_acc = 1'b1;
         end else if (prev_acc) begin
            chk("wb_ready_rd2", 64'(wb_ready), 0);
            prev_acc = 1'b0;
         end
         @(posedge clk); #1;
         wb_data = {$urandom, $urandom};
      end
      chk("alt_accepts", 64'(n_acc >= 3), 1);
      wb_valid = 1'b0; req_valid = 1'b0;
      drain();

      // Response held while a write lands in RESP.
      rsp_ready = 1'b0;
      do_req(5'd3, 5'd5);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk); got = rsp_valid;
      end
      chk("hold_rsp_seen", 64'(got), 1);
      @(posedge clk); #1;
      req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd3;
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h55;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_req_ready", 64'(req_ready), 0);
         chk("hold_rsp_valid", 64'(rsp_valid), 1);
         w = wb_ready;
         @(posedge clk); #1;
         if (w) wb_valid = 1'b0;
      end
      chk("hold_wb_done", 64'(wb_valid), 0);
      rsp_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk); got = req_ready;
      end
      chk("hold_next_accept", 64'(got), 1);
      @(posedge clk); #1; req_valid = 1'b0;
      drain();

      // Reset during RD2 abandons the request.
      do_wb(5'd12, 64'hC0FFEE);
      do_wb(5'd13, 64'hBEEF01);
      req_valid = 1'b1; req_rs1 = 5'd12; req_rs2 = 5'd13;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk); got = req_ready;
      end
      chk("rst_mid_accept", 64'(got), 1);
      @(posedge clk); #1; rst = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", 64'(rsp_valid), 0);
      chk("rst_mid_rs1", rsp_rs1_data, 0);
      chk("rst_mid_rs2", rsp_rs2_data, 0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;

      // Equal indices: one-cycle-faster response when the option is built in.
      do_wb(5'd9, 64'hA5);
      do_req(5'd9, 5'd9);
      drain();

      // Randomised traffic.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         wbhs = wb_valid && wb_ready;
         rqhs = req_valid && req_ready;
         @(posedge clk); #1;
         if (!wb_valid || wbhs) begin
            wb_valid = ($urandom_range(0, 99) < 40);
            wb_rd = 5'($urandom_range(0, 99) < 80 ?
                       $urandom_range(0, 7) : $urandom_range(0, 31));
            wb_data = {$urandom, $urandom};
         end
         if (!req_valid || rqhs) begin
            req_valid = ($urandom_range(0, 99) < 50);
            req_rs1 = 5'($urandom_range(0, 7));
            req_rs2 = 5'($urandom_range(0, 99) < 30 ?
                         req_rs1 : $urandom_range(0, 7));
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
      end
      wb_valid = 1'b0; req_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
